// File: rtl/spi_pkg.sv
// Shared constants and helpers for the word-oriented SPI slave.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling one.
  function automatic logic spi_sample_on_rise(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

  function automatic int spi_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_slave_word_if.sv
// Word-level transmit/receive handshake between the SPI slave and the on-chip data path.
interface spi_slave_word_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, tx_underrun
  );

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, tx_underrun
  );
endinterface

// File: rtl/spi_sync.sv
// Multi-stage synchroniser for one asynchronous pin, with edge pulses derived from
// the synchronised level and its one-cycle history.
module spi_sync #(
  parameter int STAGES  = 3,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              hist_r;

  // Synchroniser chain plus history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RST_VAL}};
      hist_r <= RST_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      hist_r <= sync_r[STAGES-1];
    end
  end

  assign q    = sync_r[STAGES-1];
  assign rise = sync_r[STAGES-1] & ~hist_r;
  assign fall = ~sync_r[STAGES-1] & hist_r;

endmodule

// File: rtl/spi_slave_word.sv
// Full-duplex, word-oriented SPI slave supporting all CPOL/CPHA modes; SPI pins are
// oversampled in the clk domain, tx words pass through a one-deep holding register.
module spi_slave_word
  import spi_pkg::*;
#(
  parameter int              DATA_W      = 8,
  parameter bit              CPOL        = 1'b0,
  parameter bit              CPHA        = 1'b0,
  parameter int              SYNC_STAGES = 3,
  parameter bit              MSB_FIRST   = 1'b1,
  parameter logic [DATA_W-1:0] IDLE_FILL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sck,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  output logic               busy,
  spi_slave_word_if.slave    bus
);

  localparam int               CNT_W       = spi_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam bit               SAMPLE_RISE = spi_sample_on_rise(CPOL, CPHA);

  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  logic sck_q_s, sck_rise_s, sck_fall_s;
  logic ss_q_s, ss_rise_s, ss_fall_s;
  logic mosi_q_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d(sck), .q(sck_q_s), .rise(sck_rise_s), .fall(sck_fall_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .d(ss_n), .q(ss_q_s), .rise(ss_rise_s), .fall(ss_fall_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_q_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  assign unused_s = ^{sck_q_s, ss_rise_s, mosi_rise_s, mosi_fall_s};

  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] rx_sr_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r;
  logic [DATA_W-1:0] tx_sr_r;
  logic              reload_pend_r;
  logic              miso_r;
  logic              underrun_r;
  logic [DATA_W-1:0] hold_r;
  logic              hold_empty_r;

  logic              sel_s;
  logic              rise_s, fall_s;
  logic              sample_s, shift_edge_s, lead_s;
  logic              load_s, shift_s, take_s, wrap_s;
  logic [DATA_W-1:0] load_word_s;
  logic [DATA_W-1:0] rx_nxt_s;
  logic [DATA_W-1:0] tx_sr_nxt_s;

  // Edge qualification: SCK activity only counts while the slave is selected.
  always_comb begin
    sel_s        = ~ss_q_s;
    rise_s       = sck_rise_s & sel_s;
    fall_s       = sck_fall_s & sel_s;
    sample_s     = SAMPLE_RISE ? rise_s : fall_s;
    shift_edge_s = SAMPLE_RISE ? fall_s : rise_s;
    lead_s       = CPOL ? fall_s : rise_s;
    wrap_s       = sample_s & (bit_cnt_r == LAST_BIT);
  end

  // Tx word load decision; CPHA=0 needs the first bit on the pin before any SCK edge.
  always_comb begin
    load_s = 1'b0;
    if (CPHA == 1'b0) begin
      load_s = ss_fall_s | (shift_edge_s & reload_pend_r);
    end else begin
      load_s = lead_s & (bit_cnt_r == {CNT_W{1'b0}});
    end
    shift_s     = shift_edge_s & ~load_s;
    take_s      = bus.tx_valid & hold_empty_r;
    load_word_s = hold_empty_r ? IDLE_FILL : hold_r;
  end

  // Next-state values of the rx and tx shift registers.
  always_comb begin
    rx_nxt_s    = rx_sr_r;
    tx_sr_nxt_s = tx_sr_r;
    if (MSB_FIRST) begin
      rx_nxt_s = {rx_sr_r[DATA_W-2:0], mosi_q_s};
    end else begin
      rx_nxt_s = {mosi_q_s, rx_sr_r[DATA_W-1:1]};
    end
    if (load_s) begin
      tx_sr_nxt_s = load_word_s;
    end else if (shift_s) begin
      if (MSB_FIRST) begin
        tx_sr_nxt_s = {tx_sr_r[DATA_W-2:0], 1'b0};
      end else begin
        tx_sr_nxt_s = {1'b0, tx_sr_r[DATA_W-1:1]};
      end
    end else begin
      tx_sr_nxt_s = tx_sr_r;
    end
  end

  // Receive path: bit counter, assembly register and completed-word strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r  <= {CNT_W{1'b0}};
      rx_sr_r    <= {DATA_W{1'b0}};
      rx_data_r  <= {DATA_W{1'b0}};
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= wrap_s;
      if (!sel_s) begin
        bit_cnt_r <= {CNT_W{1'b0}};
        rx_sr_r   <= {DATA_W{1'b0}};
      end else if (sample_s) begin
        rx_sr_r <= rx_nxt_s;
        if (wrap_s) begin
          bit_cnt_r <= {CNT_W{1'b0}};
          rx_data_r <= rx_nxt_s;
        end else begin
          bit_cnt_r <= bit_cnt_r + CNT_ONE;
        end
      end
    end
  end

  // Transmit path: a deselect drops whatever word is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr_r       <= {DATA_W{1'b0}};
      reload_pend_r <= 1'b0;
      miso_r        <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      underrun_r <= load_s & hold_empty_r;
      if (!sel_s) begin
        tx_sr_r       <= {DATA_W{1'b0}};
        reload_pend_r <= 1'b0;
        miso_r        <= 1'b0;
      end else begin
        tx_sr_r <= tx_sr_nxt_s;
        miso_r  <= out_bit(tx_sr_nxt_s);
        if (wrap_s) begin
          reload_pend_r <= 1'b1;
        end else if (load_s) begin
          reload_pend_r <= 1'b0;
        end
      end
    end
  end

  // Holding register: a handshake only happens when empty, so a same-cycle load sees it empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r       <= {DATA_W{1'b0}};
      hold_empty_r <= 1'b1;
    end else if (take_s) begin
      hold_r       <= bus.tx_data;
      hold_empty_r <= 1'b0;
    end else if (load_s) begin
      hold_empty_r <= 1'b1;
    end
  end

  assign miso            = miso_r;
  assign miso_oe         = sel_s;
  assign busy            = sel_s;
  assign bus.tx_ready    = hold_empty_r;
  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.tx_underrun = underrun_r;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: one instance per SPI mode, driven as an SPI master with
// directed words; received words are checked by a scoreboard monitor.
module tb_spi_slave_word;

  localparam int HALF  = 8;
  localparam int SETUP = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] sck_v = 4'b1100;
  logic [3:0] ss_n_v = 4'b1111;
  logic [3:0] mosi_v = 4'b0000;
  logic [3:0] tx_valid_v = 4'b0000;
  logic [7:0] tx_data_a [4];
  wire  [3:0] miso_v, oe_v, busy_v, tx_ready_v, rx_valid_v, und_v;
  wire  [7:0] rx_data_a [4];

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_slave_word_if #(.DATA_W(8)) bus ();
    assign bus.tx_data   = tx_data_a[g];
    assign bus.tx_valid  = tx_valid_v[g];
    assign tx_ready_v[g] = bus.tx_ready;
    assign rx_valid_v[g] = bus.rx_valid;
    assign und_v[g]      = bus.tx_underrun;
    assign rx_data_a[g]  = bus.rx_data;

    spi_slave_word #(
      .DATA_W(8), .CPOL((g >= 2) ? 1'b1 : 1'b0), .CPHA((g % 2 == 1) ? 1'b1 : 1'b0),
      .SYNC_STAGES(3), .MSB_FIRST(1'b1), .IDLE_FILL(8'hFF)
    ) dut (
      .clk(clk), .rst_n(rst_n), .sck(sck_v[g]), .ss_n(ss_n_v[g]), .mosi(mosi_v[g]),
      .miso(miso_v[g]), .miso_oe(oe_v[g]), .busy(busy_v[g]), .bus(bus)
    );
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_rx_q [$];
  int rx_cnt [4] = '{0, 0, 0, 0};
  int und_cnt [4] = '{0, 0, 0, 0};
  int rdy_rise [4] = '{0, 0, 0, 0};
  logic [3:0] rdy_prev = 4'hF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every rx_valid pops the oldest expected word.
  initial forever begin
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      if (rx_valid_v[m]) begin
        rx_cnt[m]++;
        if (exp_rx_q.size() == 0) begin
          n_checks++;
          $display("FAIL rx_unexpected: inst %0d got %0h, expected no word", m, rx_data_a[m]);
        end else begin
          check("rx_data", {24'h0, rx_data_a[m]}, {24'h0, exp_rx_q.pop_front()});
        end
      end
      if (und_v[m]) und_cnt[m]++;
      if (tx_ready_v[m] && !rdy_prev[m]) rdy_rise[m]++;
      rdy_prev[m] = tx_ready_v[m];
    end
  end

  task automatic push(input int m, input logic [7:0] d);
    bit done = 1'b0;
    tx_data_a[m]  = d;
    tx_valid_v[m] = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      if (tx_ready_v[m]) done = 1'b1;
      wait_clk(1);
    end
    tx_valid_v[m] = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL push_timeout: inst %0d tx_ready stayed %0b, expected 1", m, tx_ready_v[m]);
    end
  endtask

  task automatic select(input int m);
    ss_n_v[m] = 1'b0;
    wait_clk(SETUP);
  endtask

  task automatic deselect(input int m);
    wait_clk(HALF);
    ss_n_v[m] = 1'b1;
    wait_clk(SETUP);
  endtask

  // Master side of nbits bit periods; returns the MISO bits seen at the sample edge.
  task automatic spi_bits(input int m, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int bi = 7 - i;
      if (!cpha) begin
        mosi_v[m] = mo[bi];
        wait_clk(HALF);
        mi[bi] = miso_v[m];
        sck_v[m] = ~cpol;
        wait_clk(HALF);
        sck_v[m] = cpol;
      end else begin
        wait_clk(HALF);
        sck_v[m] = ~cpol;
        mosi_v[m] = mo[bi];
        wait_clk(HALF);
        mi[bi] = miso_v[m];
        sck_v[m] = cpol;
      end
    end
  endtask

  task automatic xfer_word(input int m, input logic [7:0] mo, input logic [7:0] exp_mi, input string name);
    logic [7:0] got;
    exp_rx_q.push_back(mo);
    spi_bits(m, mo, 8, got);
    check(name, {24'h0, got}, {24'h0, exp_mi});
  endtask

  function automatic logic [31:0] out_state(input int m);
    return {18'h0, miso_v[m], oe_v[m], tx_ready_v[m], rx_valid_v[m], und_v[m], busy_v[m], rx_data_a[m]};
  endfunction

  localparam logic [31:0] RST_STATE = {18'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

  initial begin
    int c0, r0, u0;
    logic [7:0] junk;
    for (int m = 0; m < 4; m++) tx_data_a[m] = 8'h00;
    wait_clk(3);
    for (int m = 0; m < 4; m++) check("reset_state", out_state(m), RST_STATE);
    rst_n = 1'b1;
    wait_clk(5);

    // Mode 0 loopback
    c0 = rx_cnt[0];
    push(0, 8'hA5);
    select(0);
    xfer_word(0, 8'h3C, 8'hA5, "t1_miso");
    deselect(0);
    check("t1_rx_count", rx_cnt[0] - c0, 1);

    // 0x81 both ways in every mode
    for (int m = 0; m < 4; m++) begin
      r0 = rdy_rise[m];
      push(m, 8'h81);
      select(m);
      xfer_word(m, 8'h81, 8'h81, "t2_miso");
      deselect(m);
      check("t2_ready_rises", rdy_rise[m] - r0, 1);
    end

    // Underrun in mode 1 with an empty holding register
    u0 = und_cnt[1];
    select(1);
    xfer_word(1, 8'h12, 8'hFF, "t3_miso_w0");
    xfer_word(1, 8'h34, 8'hFF, "t3_miso_w1");
    deselect(1);
    check("t3_underruns", und_cnt[1] - u0, 2);

    // Back-to-back words in mode 0
    c0 = rx_cnt[0];
    push(0, 8'h11);
    select(0);
    push(0, 8'h22);
    xfer_word(0, 8'hC3, 8'h11, "t4_miso_w0");
    xfer_word(0, 8'h3C, 8'h22, "t4_miso_w1");
    deselect(0);
    check("t4_rx_count", rx_cnt[0] - c0, 2);

    // Abort after 5 bits, then a full word
    c0 = rx_cnt[0];
    select(0);
    spi_bits(0, 8'hF0, 5, junk);
    deselect(0);
    push(0, 8'h96);
    select(0);
    xfer_word(0, 8'h5A, 8'h96, "t5_miso");
    deselect(0);
    check("t5_rx_count", rx_cnt[0] - c0, 1);
    check("t5_rx_data", {24'h0, rx_data_a[0]}, 32'h5A);

    // Reset at bit 3, outputs must clear without a clock edge
    push(0, 8'hE0);
    select(0);
    push(0, 8'h0F);
    spi_bits(0, 8'hAA, 3, junk);
    rst_n = 1'b0;
    #2;
    check("t6_async_reset", out_state(0), RST_STATE);
    ss_n_v[0] = 1'b1;
    sck_v[0] = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    push(0, 8'hC5);
    select(0);
    xfer_word(0, 8'h39, 8'hC5, "t6_miso_after_reset");
    deselect(0);

    check("scoreboard_drained", exp_rx_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_word.md
# spi_slave_word

Parametrised SPI slave for the FPGA side of the SPI link. It is full-duplex, word-oriented and supports all four CPOL/CPHA modes. SCK, SS_n and MOSI are synchronised into the `clk` domain. Transmit words enter through a one-deep holding register with a valid/ready handshake, and received words leave as a one-cycle strobe. It replaces the fixed single-bit toggle slave and sits between the external SPI master pins and the on-chip data path.

## Interface
- `DATA_W`, 8: bits per SPI word (≥2).
- `CPOL`, 0: SCK idle level.
- `CPHA`, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- `SYNC_STAGES`, 3: synchroniser depth (≥2).
- `MSB_FIRST`, 1: 1 = MSB shifted first; 0 = LSB first.
- `IDLE_FILL`, 0: `DATA_W`-bit word sent when no tx data is available.

Ports:
- `clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `sck` input 1: SPI clock, asynchronous.
- `ss_n` input 1: slave select, active-low, asynchronous.
- `mosi` input 1: master-out data, asynchronous.
- `miso` output 1: slave-out data.
- `miso_oe` output 1: tri-state enable for `miso`; high while selected.
- `tx_data` input DATA_W: word to transmit.
- `tx_valid` input 1: `tx_data` valid.
- `tx_ready` output 1: holding register empty.
- `rx_data` output DATA_W: last complete received word.
- `rx_valid` output 1: one-cycle strobe, `rx_data` updated.
- `tx_underrun` output 1: one-cycle strobe, `IDLE_FILL` was loaded.
- `busy` output 1: synchronised select active.

## Operation
- **Synchronisers.** `sck`, `ss_n` and `mosi` pass through `SYNC_STAGES` flops.
  - Reset values: `sck` sync = `CPOL`, `ss_n` sync = 1, `mosi` sync = 0.
  - Edge detect compares the last two stages.
- **Edge definition.** Leading edge = rising if `CPOL`=0, else falling.
  - Sample edge = leading if `CPHA`=0, else trailing.
  - Shift edge = the other edge.
- **Tx holding register.**
  - A transfer occurs when `tx_valid & tx_ready`.
  - `tx_ready` = holding register empty.
- **Word load into shift register (tx).**
  - `CPHA`=0: load on the sync'd `ss_n` falling edge, and on the first shift edge after every `DATA_W`-th sample edge.
  - `CPHA`=1: load on the first leading edge of each word.
  - Load takes the holding word and empties the register. If the register is empty, load `IDLE_FILL` and pulse `tx_underrun`.
- **Shift register output.** `miso` = current output bit (MSB or LSB per `MSB_FIRST`). It advances one bit per shift edge, except on a load edge.
- **Receive.**
  - Each sample edge shifts sync'd `mosi` into the rx shift register and increments the bit counter.
  - At count `DATA_W` the counter wraps to 0, `rx_data` ← assembled word, and `rx_valid` pulses.
  - There is no backpressure. `rx_data` holds until the next complete word.
- **Back-to-back words.** Any number of words may be sent within one select assertion.
- **Deselect mid-word** (sync'd `ss_n` rises, counter ≠ 0):
  - The partial rx word is discarded with no `rx_valid`.
  - The counter clears.
  - The word in the tx shift register is dropped and not re-sent.
  - The holding register is unaffected.
- **Events while deselected.** SCK edges are ignored. `miso` = 0, `miso_oe` = 0.
- **Simultaneous load and handshake.** If a load and a `tx_valid` handshake occur in the same cycle, the load takes the old contents. The new word is stored, and `tx_ready` goes low next cycle.

## Timing
- **Reset values:** `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, `busy`=0, counter=0. Reset takes effect immediately and aborts any transfer.
- **Pin-to-detect latency:** SYNC_STAGES+1 `clk` cycles from pin change to edge-detect.
- **`rx_valid` timing:** asserted in the cycle after the final sample edge is detected.
- **`miso` update:** in the cycle after shift-edge or load detection.
- **`tx_ready` timing:** rises the cycle after a load that empties the holding register.
- **Clock ratio requirement:**
  - SCK high and low phases ≥ SYNC_STAGES+2 `clk` periods each.
  - `ss_n` falling to first SCK edge ≥ SYNC_STAGES+3 `clk` periods.
  - Behaviour outside these limits is undefined.

## Structure
- Package `spi_pkg`:
  - mode localparams `SPI_MODE0`..`SPI_MODE3`;
  - function `spi_sample_on_rise(cpol, cpha)`;
  - bit-counter width `$clog2(DATA_W+1)`.
- One sub-module, `spi_sync`: N-stage synchroniser with reset value parameter and rise/fall outputs. Instantiated three times.

## Test plan
- **Mode 0, byte loopback.** DATA_W=8, `tx_data`=0xA5 preloaded; master sends 0x3C. Expect MISO bits 1,0,1,0,0,1,0,1; `rx_data`=0x3C; one `rx_valid`.
- **All four modes.** Sweep CPOL/CPHA with 0x81 both ways. Expect round-trip exact and `tx_ready` re-asserted once per word.
- **Underrun.** IDLE_FILL=0xFF, no tx data, 2-word burst. Expect MISO all ones and two `tx_underrun` pulses.
- **Back-to-back.** Push 0x11 and 0x22; 2 words under one select. Expect MISO 0x11 then 0x22 and two `rx_valid` pulses.
- **Abort.** Deselect after 5 bits, then a full transfer of 0x5A. Expect no `rx_valid` for the partial word and `rx_data`=0x5A after the full word.
- **Reset mid-word.** Assert `rst_n`=0 at bit 3. Expect all outputs at reset values with no clock edge needed; the next transfer is correct.
